trisc_hex_scan: RTL and testbench
=================================

Name: trisc_hex_scan

Overview:
Time-multiplexed controller for the board's multi-digit 7-segment display. It accepts a packed hex value over a valid/ready handshake and drives one digit at a time through a single shared hex-to-segment decode path. A blanking gap between digits suppresses ghosting. It sits between the TRISC debug/register-view logic and the display pins.

Parameters:
DIGITS, 4, number of multiplexed digit positions (1..8).
SCAN_DIV, 1000, clock cycles each digit is lit (>=1).
GAP, 16, all-off clock cycles between digits (>=0; 0 means no gap state).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset_n  input  1  synchronous, active-low reset.
enable  input  1  scan enable; low blanks the display and parks the controller in IDLE.
load_valid  input  1  load_data is valid.
load_data  input  4*DIGITS  packed nibbles; nibble i drives digit i, with digit 0 = bits [3:0].
load_ready  output  1  shadow register is empty and can accept a value.
seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
digit_n  output  DIGITS  active-low one-hot digit select, registered.
frame_done  output  1  one-cycle pulse when the last digit's slot completes.

Behaviour:
- Reset (reset_n=0 at a clk edge): seg=7'h7F, digit_n all ones, load_ready=1, frame_done=0, state=IDLE, idx=0, counter=0. Display and shadow registers are cleared to 0, pending=0. Reset mid-scan or with a load pending discards everything; no partial state survives.
- Handshake: load_ready = !pending. A transfer occurs when load_valid && load_ready at a clock edge. On a transfer, shadow<=load_data and pending<=1. load_data is ignored when load_ready=0, and load_valid may be held.
- Commit: shadow moves to display and pending<=0 at one of two points: on the cycle the FSM enters SCAN_ON with idx=0 (the frame boundary), or on any cycle while in IDLE. There is no tearing mid-frame. Accept and commit cannot coincide because ready implies !pending.
- FSM states are IDLE, SCAN_ON and SCAN_GAP.
  - IDLE: outputs blank. enable=1 moves to SCAN_ON with idx=0 and counter=SCAN_DIV-1.
  - SCAN_ON: digit_n[idx]=0, all other digits 1, seg=decode(display[4*idx+:4]). counter decrements each cycle. At 0, go to SCAN_GAP with counter=GAP-1, or go directly to the next digit if GAP=0.
  - SCAN_GAP: digit_n all ones, seg=7'h7F. At counter 0, advance to SCAN_ON for the next digit.
  - Digit advance: idx wraps DIGITS-1 -> 0. On that wrap, frame_done pulses 1 for one cycle, aligned to the first cycle of the new frame.
- enable=0 in any state forces IDLE on the next edge: idx=0, counter=0, outputs blank one cycle later. Pending data is kept and committed while in IDLE.
- Output latency: seg and digit_n are registered, so they reflect the state one cycle later.
- Frame period is DIGITS*(SCAN_DIV+GAP) cycles.
- Decode table (hex digit -> seg):
  - 0..7 -> 40 79 24 30 19 12 02 78
  - 8..F -> 00 18 08 03 46 21 06 0E

Optional Feature:
Macro TRISC_HEX_LZB_EN enables leading-zero blanking.
- With the macro: digit i (i>0) outputs seg=7'h7F whenever nibbles i..DIGITS-1 of display are all zero. Its digit_n timing is unchanged. Digit 0 always shows its value.
- Without the macro: every digit shows its nibble, including leading zeros.

Decomposition:
- Package trisc_hex_pkg holds:
  - SEG_BLANK=7'h7F.
  - The 16-entry segment constant table, plus a hex_to_seg function over it.
  - The state enum {IDLE, SCAN_ON, SCAN_GAP}.
- One sub-module, trisc_scan_timer: a loadable down-counter with a zero flag, shared by the SCAN_ON and SCAN_GAP intervals.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, GAP=2.
1. Reset: hold reset_n=0 for 3 cycles, then release -> seg=7F, digit_n=1111, load_ready=1, frame_done=0.
2. Load 16'h1A3F with enable=1 -> the following sequence, then frame_done pulses once at cycle 24 relative to the first lit digit:
   - digit_n=1110 with seg=0E for 4 cycles, then 2 cycles of 1111/7F.
   - 1101/30, then 1011/08, then 0111/79, each with the same 4-on/2-gap timing.
3. Mid-frame load of 16'h0000 during digit 1 -> load_ready=0 until the wrap, digits 1..3 still show 3/A/1, and frame 2 shows 40 on all digits. A second load_valid while pending is not accepted until ready returns.
4. Drop enable during digit 2, lit cycle 2 -> next cycle the FSM is in IDLE and one cycle later outputs are 1111/7F. Re-enable -> scan restarts at digit 0 (1110).
5. Load 16'h0050:
   - With TRISC_HEX_LZB_EN, digits 3 and 2 give seg=7F, digit 1 gives 12, digit 0 gives 40.
   - Without the macro, digit 3 gives 40 and digit 2 gives 40.
6. reset_n=0 during SCAN_GAP with pending=1 -> next edge gives reset values. After release and enable, the display shows 40 on all digits (cleared), with no stale shadow data.

Source files
------------

// File: rtl/trisc_hex_pkg.sv
// trisc_hex_pkg: shared constants, the hex-to-segment table and the scan FSM state type
// for the multiplexed 7-segment display controller.
package trisc_hex_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 0 in the least significant slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN_ON,
    SCAN_GAP
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/trisc_scan_timer.sv
// trisc_scan_timer: loadable down-counter with a registered zero flag; times both the
// lit and the blanking interval of each digit slot.
module trisc_scan_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          zero_q;

  // Load takes priority; otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // Counter and zero flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/trisc_hex_scan.sv
// trisc_hex_scan: time-multiplexed 7-segment display controller. A value is accepted into
// a shadow register over valid/ready and committed to the display only at a frame boundary
// or while idle, so a frame never mixes old and new digits.
// Optional: define TRISC_HEX_LZB_EN to blank leading-zero digits (digit 0 always shown).
module trisc_hex_scan
  import trisc_hex_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned GAP      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_n,
  output logic                  frame_done
);

  localparam int unsigned DW      = 4 * DIGITS;
  localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_MAX = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] ON_LD    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  scan_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     display_q, display_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              ready_q;
  logic              wrap_q;
  logic              frame_done_q;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] digit_n_q, digit_n_d;

  logic              tmr_load_c;
  logic [CW-1:0]     tmr_val_c;
  logic              tmr_zero;
  logic              adv_c;
  logic              wrap_c;
  logic              accept_c;
  logic              commit_c;
  logic [3:0]        nib_c;

  trisc_scan_timer #(
    .CW (CW)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .zero_o     (tmr_zero)
  );

  // Next-state logic: scan sequencing, digit advance and timer reloads.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    adv_c      = 1'b0;
    wrap_c     = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      idx_d      = '0;
      tmr_load_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = SCAN_ON;
          idx_d      = '0;
          tmr_load_c = 1'b1;
          tmr_val_c  = ON_LD;
        end
        SCAN_ON: begin
          if (tmr_zero) begin
            if (GAP > 0) begin
              state_d    = SCAN_GAP;
              tmr_load_c = 1'b1;
              tmr_val_c  = GAP_LD;
            end else begin
              adv_c = 1'b1;
            end
          end
        end
        SCAN_GAP: begin
          if (tmr_zero) begin
            adv_c = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
      if (adv_c) begin
        state_d    = SCAN_ON;
        tmr_load_c = 1'b1;
        tmr_val_c  = ON_LD;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_c = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
  end

  // Shadow/display handshake: accept only when empty, commit at frame start or in IDLE.
  always_comb begin
    accept_c  = load_valid && !pending_q;
    commit_c  = pending_q && ((state_q == IDLE) || wrap_c);
    shadow_d  = accept_c ? load_data : shadow_q;
    display_d = commit_c ? shadow_q : display_q;
    pending_d = pending_q;
    if (accept_c) begin
      pending_d = 1'b1;
    end else if (commit_c) begin
      pending_d = 1'b0;
    end
  end

  // Output decode for the digit currently lit; registered below.
  always_comb begin
`ifdef TRISC_HEX_LZB_EN
    logic [DW-1:0] upper_c;
`endif
    seg_d     = SEG_BLANK;
    digit_n_d = '1;
    nib_c     = 4'(display_q >> {idx_q, 2'b00});
`ifdef TRISC_HEX_LZB_EN
    upper_c   = display_q >> {idx_q, 2'b00};
`endif
    if (state_q == SCAN_ON) begin
      digit_n_d = ~(DIGITS'(1) << idx_q);
      seg_d     = hex_to_seg(nib_c);
`ifdef TRISC_HEX_LZB_EN
      if ((idx_q != '0) && (upper_c == '0)) begin
        seg_d = SEG_BLANK;
      end
`endif
    end
  end

  // State, data and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      display_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      digit_n_q    <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      display_q    <= display_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      ready_q      <= !pending_d;
      wrap_q       <= wrap_c;
      frame_done_q <= wrap_q;
      seg_q        <= seg_d;
      digit_n_q    <= digit_n_d;
    end
  end

  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign digit_n    = digit_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_trisc_hex_scan.sv
// tb_trisc_hex_scan: directed bench for trisc_hex_scan (DIGITS=4, SCAN_DIV=4, GAP=2) with a
// frame-position model checked every cycle plus hand-computed literal expectations.
module tb_trisc_hex_scan;

  localparam int SD    = 4;
  localparam int GP    = 2;
  localparam int SLOT  = SD + GP;
  localparam int FRAME = 4 * SLOT;

`ifdef TRISC_HEX_LZB_EN
  localparam logic [6:0] ZLEAD = 7'h7F;
`else
  localparam logic [6:0] ZLEAD = 7'h40;
`endif

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  digit_n;
  logic        frame_done;

  int n_vec;
  int n_err;

  logic [6:0] segs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  trisc_hex_scan #(
    .DIGITS   (4),
    .SCAN_DIV (SD),
    .GAP      (GP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .seg        (seg),
    .digit_n    (digit_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: scanning flag, cycle position within the frame, data registers.
  bit          m_live;
  bit          m_active;
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  bit          m_pend;
  bit          m_wrap;
  logic [6:0]  e_seg;
  logic [3:0]  e_dn;
  logic        e_rdy;
  logic        e_fd;

  function automatic logic [6:0] model_seg(input bit act, input int t, input logic [15:0] d);
    int slot;
    logic [3:0] nib;
    if (!act || (t % SLOT) >= SD) return 7'h7F;
    slot = t / SLOT;
    nib  = d[slot*4 +: 4];
`ifdef TRISC_HEX_LZB_EN
    if (slot > 0 && (d >> (slot * 4)) == 16'h0) return 7'h7F;
`endif
    return segs[nib];
  endfunction

  function automatic logic [3:0] model_dn(input bit act, input int t);
    logic [3:0] one;
    one = 4'b0001;
    if (!act || (t % SLOT) >= SD) return 4'hF;
    return ~(one << (t / SLOT));
  endfunction

  // Reference model: outputs after an edge reflect the model state before it.
  always @(posedge clk) begin
    bit acc, wrap, commit;
    if (!reset_n) begin
      m_live = 1'b1; m_active = 1'b0; m_t = 0;
      m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_wrap = 1'b0;
      e_seg = 7'h7F; e_dn = 4'hF; e_rdy = 1'b1; e_fd = 1'b0;
    end else begin
      e_seg  = model_seg(m_active, m_t, m_disp);
      e_dn   = model_dn(m_active, m_t);
      e_fd   = m_wrap;
      acc    = load_valid && !m_pend;
      wrap   = m_active && enable && (m_t == FRAME - 1);
      commit = m_pend && (!m_active || wrap);
      if (commit) begin m_disp = m_shadow; m_pend = 1'b0; end
      if (acc) begin m_shadow = load_data; m_pend = 1'b1; end
      m_wrap   = wrap;
      m_t      = (m_active && enable) ? (m_t + 1) % FRAME : 0;
      m_active = enable;
      e_rdy    = !m_pend;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("seg", 16'(seg), 16'(e_seg));
      chk("digit_n", 16'(digit_n), 16'(e_dn));
      chk("load_ready", 16'(load_ready), 16'(e_rdy));
      chk("frame_done", 16'(frame_done), 16'(e_fd));
    end
  end

  task automatic wait_dn(input logic [3:0] v, input int budget);
    int i;
    i = 0;
    while (digit_n !== v && i < budget) begin @(negedge clk); i++; end
    if (digit_n !== v) begin
      n_vec++; n_err++;
      $display("FAIL wait_digit_n: got %b expected %b within %0d cycles", digit_n, v, budget);
    end
  endtask

  task automatic wait_ready(input int budget);
    int i;
    i = 0;
    while (load_ready !== 1'b1 && i < budget) begin @(negedge clk); i++; end
    if (load_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_ready: got %b expected 1 within %0d cycles", load_ready, budget);
    end
  endtask

  task automatic wait_fd(input int budget);
    int i;
    i = 0;
    while (frame_done !== 1'b1 && i < budget) begin @(negedge clk); i++; end
    if (frame_done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_frame_done: got %b expected 1 within %0d cycles", frame_done, budget);
    end
  endtask

  task automatic load(input logic [15:0] v);
    wait_ready(40);
    load_valid = 1'b1;
    load_data  = v;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    logic [3:0] dn_exp [4];
    logic [6:0] sg_exp [4];
    dn_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
    sg_exp = '{7'h0E, 7'h30, 7'h08, 7'h79};
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = '0;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_digit_n", 16'(digit_n), 16'hF);
    chk("rst_ready", 16'(load_ready), 16'h1);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    reset_n = 1'b1;

    // 2: load 1A3F and follow one full frame
    load(16'h1A3F);
    enable = 1'b1;
    wait_dn(4'hE, 10);
    for (int k = 0; k <= 24; k++) begin
      if (k < 24) begin
        chk("t2_digit_n", 16'(digit_n), 16'(((k % 6) < 4) ? dn_exp[k / 6] : 4'hF));
        chk("t2_seg", 16'(seg), 16'(((k % 6) < 4) ? sg_exp[k / 6] : 7'h7F));
        chk("t2_fd_low", 16'(frame_done), 16'h0);
        @(negedge clk);
      end else begin
        chk("t2_fd_pulse", 16'(frame_done), 16'h1);
        chk("t2_wrap_digit", 16'(digit_n), 16'hE);
      end
    end

    // 3: mid-frame load 0000 during digit 1, second load held while pending
    wait_dn(4'hD, 20);
    load(16'h0000);
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    chk("t3_ready_low", 16'(load_ready), 16'h0);
    wait_ready(30);
    @(negedge clk);
    load_valid = 1'b0;
    chk("t3_fd", 16'(frame_done), 16'h1);
    chk("t3_seg0", 16'(seg), 16'h40);
    chk("t3_dn0", 16'(digit_n), 16'hE);
    chk("t3_second_taken", 16'(load_ready), 16'h0);
    wait_ready(30);
    wait_fd(5);
    chk("t3_ffff_seg", 16'(seg), 16'h0E);

    // 4: drop enable during digit 2 lit cycle 2, then re-enable
    wait_dn(4'hB, 20);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t4_lag_dn", 16'(digit_n), 16'hB);
    @(negedge clk);
    chk("t4_blank_dn", 16'(digit_n), 16'hF);
    chk("t4_blank_seg", 16'(seg), 16'h7F);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_restart_dn", 16'(digit_n), 16'hE);
    chk("t4_restart_seg", 16'(seg), 16'h0E);

    // 5: leading zeros
    load(16'h0050);
    wait_ready(40);
    wait_fd(5);
    chk("t5_d0", 16'(seg), 16'h40);
    wait_dn(4'hD, 10);
    chk("t5_d1", 16'(seg), 16'h12);
    wait_dn(4'hB, 10);
    chk("t5_d2", 16'(seg), 16'(ZLEAD));
    wait_dn(4'h7, 10);
    chk("t5_d3", 16'(seg), 16'(ZLEAD));

    // 6: reset during gap with a load pending
    wait_fd(30);
    load(16'hBEEF);
    chk("t6_pending", 16'(load_ready), 16'h0);
    wait_dn(4'hF, 10);
    chk("t6_gap_pending", 16'(load_ready), 16'h0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_seg", 16'(seg), 16'h7F);
    chk("t6_rst_dn", 16'(digit_n), 16'hF);
    chk("t6_rst_ready", 16'(load_ready), 16'h1);
    chk("t6_rst_fd", 16'(frame_done), 16'h0);
    reset_n = 1'b1;
    wait_dn(4'hE, 10);
    chk("t6_d0", 16'(seg), 16'h40);
    wait_dn(4'hD, 10);
    chk("t6_d1", 16'(seg), 16'(ZLEAD));
    wait_dn(4'hB, 10);
    chk("t6_d2", 16'(seg), 16'(ZLEAD));
    wait_dn(4'h7, 10);
    chk("t6_d3", 16'(seg), 16'(ZLEAD));

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
